// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like bus between the instruction-fetch
// master and the data master. A grant is held until the slave accepts the
// address. The owner of every accepted request is queued in order so that
// each response is steered back to the master that issued it.
module sram_bus_arbiter #(
  parameter int unsigned OUTST_DEPTH = 4,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned PW = $clog2(OUTST_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [OUTST_DEPTH-1:0] owner;   // 1 = data master, 0 = inst master
  logic [SW-1:0]          starve;

  logic sel_i, sel_d;
  logic full, accepted, pop, head;

  assign full     = (count == CW'(OUTST_DEPTH));
  assign head     = owner[rd_ptr];
  assign pop      = bus_data_ok && (count != '0);
  assign accepted = bus_req && bus_addr_ok;

  // Pick the master: a held grant wins outright, otherwise data wins unless
  // the inst master has waited long enough to be forced through.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (state)
      HOLD_I:  sel_i = 1'b1;
      HOLD_D:  sel_d = 1'b1;
      default: begin
        sel_d = data_req && !(inst_req && (starve == SW'(STARVE_MAX)));
        sel_i = inst_req && !sel_d;
      end
    endcase
  end

  // Bus request and field mux; inst fields are presented when idle.
  always_comb begin
    bus_req      = (sel_i || sel_d) && !full;
    bus_wr       = sel_d ? data_wr    : inst_wr;
    bus_size     = sel_d ? data_size  : inst_size;
    bus_addr     = sel_d ? data_addr  : inst_addr;
    bus_wdata    = sel_d ? data_wdata : inst_wdata;
    inst_addr_ok = accepted && sel_i;
    data_addr_ok = accepted && sel_d;
    inst_data_ok = pop && !head;
    data_data_ok = pop && head;
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
  end

  // Grant FSM: latch the winner while the slave stalls the address phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus_req && !bus_addr_ok)
            state <= sel_d ? HOLD_D : HOLD_I;
        end
        HOLD_I, HOLD_D: begin
          if (accepted)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-order owner FIFO of accepted requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      owner  <= '0;
    end else begin
      if (accepted) begin
        owner[wr_ptr] <= sel_d;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({accepted, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: waiting cycles of the inst master outside its own grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve <= '0;
    end else if (state != HOLD_I && starve != SW'(STARVE_MAX)) begin
      starve <= starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: arbitration, grant hold, full FIFO,
// starvation override, response routing and reset drop.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTST_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    settle();
    check("rst_bus_req", {31'b0, bus_req}, 0);
    check("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
    check("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 0);
    next_cycle();
    reset = 0;

    // Single IF read
    inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1;
    settle();
    check("if_bus_req", {31'b0, bus_req}, 1);
    check("if_bus_addr", bus_addr, 32'hBFC00000);
    check("if_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'h2);
    next_cycle();
    inst_req = 0; bus_addr_ok = 0;
    settle();
    check("if_no_early_resp", {30'b0, inst_data_ok, data_data_ok}, 0);
    next_cycle();
    bus_data_ok = 1; bus_rdata = 32'h3C1D0000;
    settle();
    check("if_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h2);
    check("if_rdata", inst_rdata, 32'h3C1D0000);
    next_cycle();
    bus_data_ok = 0;

    // Conflict: data wins first, IF next
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_addr = 32'h1000; data_wr = 1; data_wdata = 32'hDEADBEEF;
    bus_addr_ok = 1;
    settle();
    check("cf_bus_addr", bus_addr, 32'h1000);
    check("cf_bus_wr", {31'b0, bus_wr}, 1);
    check("cf_bus_wdata", bus_wdata, 32'hDEADBEEF);
    check("cf_addr_ok_d", {30'b0, inst_addr_ok, data_addr_ok}, 32'h1);
    next_cycle();
    data_req = 0; data_wr = 0;
    settle();
    check("cf_addr_ok_i", {30'b0, inst_addr_ok, data_addr_ok}, 32'h2);
    check("cf_bus_addr_i", bus_addr, 32'hBFC00004);
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h11111111;
    settle();
    check("cf_resp1_d", {30'b0, inst_data_ok, data_data_ok}, 32'h1);
    check("cf_rdata_d", data_rdata, 32'h11111111);
    next_cycle();
    bus_rdata = 32'h22222222;
    settle();
    check("cf_resp2_i", {30'b0, inst_data_ok, data_data_ok}, 32'h2);
    next_cycle();
    bus_data_ok = 0;

    // Grant hold: IF stalled three cycles while data requests
    inst_req = 1; inst_addr = 32'hBFC00008;
    settle();
    check("gh_req0", {31'b0, bus_req}, 1);
    next_cycle();
    data_req = 1; data_addr = 32'h2000;
    for (int i = 1; i < 3; i++) begin
      settle();
      check("gh_hold_addr", bus_addr, 32'hBFC00008);
      check("gh_no_ack", {30'b0, inst_addr_ok, data_addr_ok}, 0);
      next_cycle();
    end
    bus_addr_ok = 1;
    settle();
    check("gh_accept_i", {30'b0, inst_addr_ok, data_addr_ok}, 32'h2);
    check("gh_accept_addr", bus_addr, 32'hBFC00008);
    next_cycle();
    inst_req = 0;
    settle();
    check("gh_then_d", {30'b0, inst_addr_ok, data_addr_ok}, 32'h1);
    check("gh_then_d_addr", bus_addr, 32'h2000);
    next_cycle();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    settle();
    check("gh_resp_i", {30'b0, inst_data_ok, data_data_ok}, 32'h2);
    next_cycle();
    settle();
    check("gh_resp_d", {30'b0, inst_data_ok, data_data_ok}, 32'h1);
    next_cycle();
    bus_data_ok = 0;

    // Full FIFO
    data_req = 1; data_addr = 32'h3000; bus_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("ff_fill", {31'b0, data_addr_ok}, 1);
      next_cycle();
    end
    settle();
    check("ff_full_req", {31'b0, bus_req}, 0);
    check("ff_full_ack", {31'b0, data_addr_ok}, 0);
    next_cycle();
    bus_data_ok = 1;
    settle();
    check("ff_pop_same_req", {31'b0, bus_req}, 0);
    check("ff_pop_resp", {31'b0, data_data_ok}, 1);
    next_cycle();
    bus_data_ok = 0;
    settle();
    check("ff_after_pop_ack", {31'b0, data_addr_ok}, 1);
    next_cycle();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("ff_drain", {30'b0, inst_data_ok, data_data_ok}, 32'h1);
      next_cycle();
    end
    settle();
    check("ff_spurious", {30'b0, inst_data_ok, data_data_ok}, 0);
    next_cycle();

    // Starvation: IF forced through on its 9th waiting cycle
    inst_req = 1; inst_addr = 32'hBFC00010;
    data_req = 1; data_addr = 32'h4000; bus_addr_ok = 1; bus_data_ok = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("sv_data_wins", {30'b0, inst_addr_ok, data_addr_ok}, 32'h1);
      next_cycle();
    end
    settle();
    check("sv_if_forced", {30'b0, inst_addr_ok, data_addr_ok}, 32'h2);
    check("sv_if_addr", bus_addr, 32'hBFC00010);
    next_cycle();
    settle();
    check("sv_cleared", {30'b0, inst_addr_ok, data_addr_ok}, 32'h1);
    check("sv_resp_i", {30'b0, inst_data_ok, data_data_ok}, 32'h2);
    next_cycle();
    inst_req = 0; data_req = 0; bus_addr_ok = 0;
    settle();
    check("sv_resp_d", {30'b0, inst_data_ok, data_data_ok}, 32'h1);
    next_cycle();
    bus_data_ok = 0;

    // Reset with two requests outstanding
    data_req = 1; data_addr = 32'h5000; bus_addr_ok = 1;
    next_cycle();
    next_cycle();
    data_req = 0; bus_addr_ok = 0;
    reset = 1;
    settle();
    check("rm_bus_req", {31'b0, bus_req}, 0);
    next_cycle();
    reset = 0;
    bus_data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rm_spurious", {30'b0, inst_data_ok, data_data_ok}, 0);
      next_cycle();
    end
    bus_data_ok = 0;
    inst_req = 1; inst_addr = 32'hBFC00020; bus_addr_ok = 1;
    settle();
    check("rm_new_ack", {30'b0, inst_addr_ok, data_addr_ok}, 32'h2);
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    settle();
    check("rm_new_resp", {30'b0, inst_data_ok, data_data_ok}, 32'h2);
    next_cycle();
    bus_data_ok = 0;
    settle();
    check("rm_empty", {30'b0, inst_data_ok, data_data_ok}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
